// File: rtl/four_state_stepper_pkg.sv
// Shared types and constants for the four-state stepper: state encoding, LED/7-segment decode, direction codes.
package four_state_stepper_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_0 = 2'd0,
      ST_1 = 2'd1,
      ST_2 = 2'd2,
      ST_3 = 2'd3
   } state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Active-low {g,f,e,d,c,b,a} digit patterns, indexed by state.
   localparam logic [6:0] SEG_DIGIT [0:3] = '{
      7'b1000000,
      7'b1111001,
      7'b0100100,
      7'b0110000
   };

   function automatic logic [3:0] led_onehot(input state_e s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/four_state_stepper_btn_debouncer.sv
// Pushbutton front end: 2-FF synchronizer, stability counter, arming latch and one-cycle press strobe.
module btn_debouncer #(
   parameter  int DEBOUNCE_CYCLES = 50000,
   localparam int DB_W            = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            btn_s_q;
   logic [1:0]      vld_q;
   logic            stable_q;
   logic            stable_d;
   logic            stable_prev_q;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] cnt_d;
   logic            armed_q;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q + DB_W'(1);
      if (btn_s_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = btn_s_q;
         cnt_d    = '0;
      end
   end

   // vld_q keeps the reset value of the sync chain from arming a button that is held through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= 1'b0;
         btn_s_q       <= 1'b0;
         vld_q         <= 2'b00;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
         armed_q       <= 1'b0;
      end else begin
         sync1_q       <= btn_i;
         btn_s_q       <= sync1_q;
         vld_q         <= {vld_q[0], 1'b1};
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         cnt_q         <= cnt_d;
         if (vld_q[1] && !btn_s_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign press_o = stable_q & ~stable_prev_q & armed_q;

endmodule

// File: rtl/four_state_stepper.sv
// Four-state up/down sequencer stepped by debounced button presses, with registered LED and 7-segment decode.
//   state | meaning
//   ST_0  | digit 0, led[0]
//   ST_1  | digit 1, led[1]
//   ST_2  | digit 2, led[2]
//   ST_3  | digit 3, led[3]  (wraps to ST_0 going up, from ST_0 going down)
module four_state_stepper
   import four_state_stepper_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 50000,
   localparam int DB_W            = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn,
   input  logic               sw_en,
   input  logic               dir,
   output logic [STATE_W-1:0] Q,
   output logic               step_pulse,
   output logic [3:0]         led,
   output logic [6:0]         seg
);

   logic   press;
   logic   dir_sync1_q;
   logic   dir_s_q;
   state_e state_q;
   state_e state_d;
   logic   step_q;
   logic [3:0] led_q;
   logic [6:0] seg_q;

   btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debouncer (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn),
      .press_o (press)
   );

   always_comb begin
      state_d = state_e'(state_q + 2'd1);
      if (dir_s_q == DIR_DOWN) begin
         state_d = state_e'(state_q - 2'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_sync1_q <= 1'b0;
         dir_s_q     <= 1'b0;
         state_q     <= ST_0;
         step_q      <= 1'b0;
         led_q       <= 4'b0001;
         seg_q       <= SEG_DIGIT[0];
      end else begin
         dir_sync1_q <= dir;
         dir_s_q     <= dir_sync1_q;
         step_q      <= 1'b0;
         // A press seen while sw_en is low is dropped, not held for later.
         if (press && sw_en) begin
            state_q <= state_d;
            step_q  <= 1'b1;
            led_q   <= led_onehot(state_d);
            seg_q   <= SEG_DIGIT[state_d];
         end
      end
   end

   assign Q          = state_q;
   assign step_pulse = step_q;
   assign led        = led_q;
   assign seg        = seg_q;

endmodule
